// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with prescaler.
// One-shot or periodic; one-cycle terminal-count pulse.
module down_counter_timer #(
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         mode,
  input  logic [P-1:0] prescale,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] r_q, r_d;
  logic [P-1:0] pc_q, pc_d;
  logic         tc_q, tc_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tick;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    pc_d    = pc_q;
    tc_d    = 1'b0;
    tick    = 1'b0;
    if (stop) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        pc_d    = '0;
      end
    end else if (load) begin
      r_d     = load_data;
      count_d = load_data;
      pc_d    = '0;
      if (state_q == DONE) state_d = IDLE;
    end else if (start && state_q != RUN
                 && r_q != '0) begin
      state_d = RUN;
      count_d = r_q;
      pc_d    = '0;
    end else if (state_q == RUN && en) begin
      if (pc_q == prescale) begin
        pc_d = '0;
        tick = 1'b1;
      end else begin
        pc_d = pc_q + P'(1);
      end
    end

    // count 0 in RUN only arises from load 0; it then just holds
    if (tick) begin
      if (count_q > N'(1)) begin
        count_d = count_q - N'(1);
      end else if (count_q == N'(1)) begin
        tc_d = 1'b1;
        if (mode) begin
          count_d = r_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      r_q     <= '0;
      pc_q    <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: vector table,
// directed corner sequences, random vs reference model.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       load;
  logic [7:0] load_data;
  logic       start;
  logic       stop;
  logic       en;
  logic       mode;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: 0 idle, 1 run, 2 done
  int m_st, m_cnt, m_r, m_pc;
  bit m_tc;

  down_counter_timer #(.N(8), .P(4)) dut (
    .clk(clk), .resetn(resetn),
    .load(load), .load_data(load_data),
    .start(start), .stop(stop), .en(en),
    .mode(mode), .prescale(prescale),
    .count(count), .tc(tc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       ld;
    bit [7:0] d;
    bit       st;
    bit       sp;
    bit       en;
    bit       md;
    bit [3:0] ps;
    int       c;
    bit       tc;
    bit       b;
    bit       dn;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(
    bit ld, bit [7:0] d, bit st, bit sp,
    bit e, bit md, bit [3:0] ps,
    int c, bit t, bit b, bit dn);
    vec_t v;
    v.ld = ld; v.d = d; v.st = st;
    v.sp = sp; v.en = e; v.md = md;
    v.ps = ps; v.c = c; v.tc = t;
    v.b = b; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input int c,
                     input bit t, input bit b,
                     input bit d);
    n_tests++;
    if (count !== 8'(c) || tc !== t ||
        busy !== b || done !== d) begin
      n_fail++;
      $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
               nm, count, tc, busy, done, c, t, b, d);
    end
  endtask

  task automatic idle_in();
    load = 0; load_data = 0; start = 0;
    stop = 0; en = 0; mode = 0; prescale = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    resetn = 0;
    #2;
    chk("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    resetn = 1;
    m_st = 0; m_cnt = 0; m_r = 0;
    m_pc = 0; m_tc = 0;
  endtask

  task automatic mstep();
    m_tc = 0;
    if (stop) begin
      if (m_st != 0) begin
        m_st = 0;
        m_pc = 0;
      end
    end else if (load) begin
      m_r = load_data;
      m_cnt = load_data;
      m_pc = 0;
      if (m_st == 2) m_st = 0;
    end else if (start && m_st != 1 && m_r != 0) begin
      m_st = 1;
      m_cnt = m_r;
      m_pc = 0;
    end else if (m_st == 1 && en) begin
      if (m_pc == int'(prescale)) begin
        m_pc = 0;
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else if (m_cnt == 1) begin
          m_tc = 1;
          if (mode) m_cnt = m_r;
          else begin
            m_cnt = 0;
            m_st = 2;
          end
        end
      end else begin
        m_pc = (m_pc + 1) % 16;
      end
    end
  endtask

  initial begin
    idle_in();
    resetn = 0;
    #2;
    chk("por", 0, 0, 0, 0);
    #6;
    resetn = 1;
    @(posedge clk);
    #1;

    // per-cycle vectors, expectations after each edge
    vt[0]  = mk(1, 3, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    vt[1]  = mk(0, 0, 1, 0, 1, 0, 0, 3, 0, 1, 0);
    vt[2]  = mk(0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0);
    vt[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
    vt[4]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    vt[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vt[6]  = mk(1, 7, 1, 0, 0, 0, 0, 7, 0, 0, 0);
    vt[7]  = mk(0, 0, 1, 0, 1, 1, 0, 7, 0, 1, 0);
    vt[8]  = mk(0, 0, 0, 0, 1, 1, 0, 6, 0, 1, 0);
    vt[9]  = mk(1, 9, 0, 0, 1, 1, 0, 9, 0, 1, 0);
    vt[10] = mk(0, 0, 0, 0, 1, 1, 0, 8, 0, 1, 0);
    vt[11] = mk(1, 2, 0, 1, 1, 1, 0, 8, 0, 0, 0);
    vt[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[13] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[14] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[15] = mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    vt[16] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 18; i++) begin
      load = vt[i].ld; load_data = vt[i].d;
      start = vt[i].st; stop = vt[i].sp;
      en = vt[i].en; mode = vt[i].md;
      prescale = vt[i].ps;
      cyc();
      chk($sformatf("vec%0d", i), vt[i].c,
          vt[i].tc, vt[i].b, vt[i].dn);
    end

    // async reset mid-count, no edge needed
    do_reset();
    load = 1; load_data = 5;
    cyc();
    load = 0; start = 1;
    cyc();
    start = 0;
    chk("pre_rst", 5, 0, 1, 0);
    #2;
    resetn = 0;
    #1;
    chk("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    resetn = 1;
    cyc();
    chk("post_rst", 0, 0, 0, 0);

    // periodic R=4 P=2 over three periods
    do_reset();
    load = 1; load_data = 4;
    mode = 1; prescale = 2;
    cyc();
    load = 0; start = 1; en = 1;
    cyc();
    start = 0;
    chk("per_start", 4, 0, 1, 0);
    for (int j = 1; j <= 36; j++) begin
      cyc();
      chk($sformatf("per%0d", j),
          4 - ((j / 3) % 4),
          (j % 12) == 0, 1, 0);
    end

    // en gating, periodic R=2 P=0
    do_reset();
    load = 1; load_data = 2; mode = 1;
    cyc();
    load = 0; start = 1;
    cyc();
    start = 0;
    chk("en_start", 2, 0, 1, 0);
    begin
      bit pat[4];
      int ec[4];
      bit et[4];
      pat = '{1, 0, 1, 0};
      ec  = '{1, 1, 2, 2};
      et  = '{0, 0, 1, 0};
      for (int j = 0; j < 4; j++) begin
        en = pat[j];
        cyc();
        chk($sformatf("en%0d", j), ec[j],
            et[j], 1, 0);
      end
    end

    // randomized vs reference model
    do_reset();
    for (int j = 0; j < 3000; j++) begin
      load = ($urandom_range(0, 11) == 0);
      load_data = ($urandom_range(0, 7) == 0) ?
                  8'd0 : 8'($urandom_range(1, 6));
      start = ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 29) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        mode = ~mode;
      if ($urandom_range(0, 24) == 0)
        prescale = ($urandom_range(0, 3) == 0) ?
                   4'($urandom_range(0, 15)) :
                   4'($urandom_range(0, 2));
      mstep();
      cyc();
      chk("rand", m_cnt, m_tc, m_st == 1, m_st == 2);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
